// File: rtl/led_shift_chain_driver.sv
`default_nettype none
// ============================================================================
// Module : led_shift_chain_driver
// Desc   : Serial LED / shift-register driver. It shifts NUM_CHAINS parallel
//          chains of WIDTH bits on a shared divided sclk, then pulses slatch.
//          Optional macro LED_SHIFT_REPEAT_EN: the last accepted frame is
//          refreshed automatically while no new frame is offered.
// Rev    : 1.0  initial release
// ============================================================================

module led_shift_chain_driver #(
    parameter int WIDTH       = 8,
    parameter int NUM_CHAINS  = 1,
    parameter int CLK_DIV     = 0,
    parameter int LATCH_TICKS = 1,
    parameter int LSB_FIRST   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_valid,
    output logic                          frame_ready,
    input  logic [NUM_CHAINS*WIDTH-1:0]   frame_data,
    output logic [NUM_CHAINS-1:0]         sdata,
    output logic                          sclk,
    output logic                          slatch,
    output logic                          busy,
    output logic                          done
);

    localparam int c_bw     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_cycles = LATCH_TICKS * (CLK_DIV + 1);
    localparam int c_dw     = (c_cycles > 1) ? $clog2(c_cycles) : 1;

    localparam logic [c_dw-1:0] c_phase_last = c_dw'(CLK_DIV);
    localparam logic [c_dw-1:0] c_latch_last = c_dw'(c_cycles - 1);
    localparam logic [c_bw-1:0] c_bit_last   = c_bw'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT_LO = 2'd1,
        S_SHIFT_HI = 2'd2,
        S_LATCH    = 2'd3
    } state_t;

    state_t                        r_state;
    logic [c_dw-1:0]               r_div;
    logic [c_bw-1:0]               r_bit;
    logic [NUM_CHAINS*WIDTH-1:0]   r_shreg;
    logic [NUM_CHAINS-1:0]         r_sdata;
    logic                          r_sclk;
    logic                          r_slatch;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_ready;

    logic                          w_start;
    logic [NUM_CHAINS*WIDTH-1:0]   w_src;

    // Bit emitted by every chain for shift position idx, honouring bit order.
    function automatic logic [NUM_CHAINS-1:0] f_pick(
        input logic [NUM_CHAINS*WIDTH-1:0] data,
        input logic [c_bw-1:0]             idx
    );
        logic [NUM_CHAINS-1:0]       bits;
        logic [NUM_CHAINS*WIDTH-1:0] sh;
        int                          pos;
        pos = (LSB_FIRST != 0) ? int'(idx) : (WIDTH - 1 - int'(idx));
        for (int c = 0; c < NUM_CHAINS; c++) begin
            sh      = data >> (c * WIDTH + pos);
            bits[c] = sh[0];
        end
        return bits;
    endfunction

`ifdef LED_SHIFT_REPEAT_EN
    logic r_have;

    // A fresh frame always wins over refreshing the stored one.
    always_comb begin
        w_start = frame_valid;
        w_src   = frame_data;
        if (!frame_valid && r_have) begin
            w_start = 1'b1;
            w_src   = r_shreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have <= 1'b0;
        end else if (r_state == S_IDLE && frame_valid) begin
            r_have <= 1'b1;
        end
    end
`else
    always_comb begin
        w_start = frame_valid;
        w_src   = frame_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_shreg  <= '0;
            r_sdata  <= '0;
            r_sclk   <= 1'b0;
            r_slatch <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_SHIFT_LO;
                        r_shreg <= w_src;
                        r_sdata <= f_pick(w_src, '0);
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                S_SHIFT_LO: begin
                    if (r_div == c_phase_last) begin
                        r_state <= S_SHIFT_HI;
                        r_sclk  <= 1'b1;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (r_div == c_phase_last) begin
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit == c_bit_last) begin
                            r_state  <= S_LATCH;
                            r_slatch <= 1'b1;
                            r_sdata  <= '0;
                        end else begin
                            r_state <= S_SHIFT_LO;
                            r_bit   <= r_bit + 1'b1;
                            r_sdata <= f_pick(r_shreg, r_bit + 1'b1);
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_div == c_latch_last) begin
                        r_state  <= S_IDLE;
                        r_div    <= '0;
                        r_bit    <= '0;
                        r_slatch <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_ready  <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign frame_ready = r_ready;
    assign sdata       = r_sdata;
    assign sclk        = r_sclk;
    assign slatch      = r_slatch;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_led_shift_chain_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_led_shift_chain_driver
// Desc   : Self-checking bench for led_shift_chain_driver (three configs).
// Rev    : 1.0  initial release
// ============================================================================

module tb_led_shift_chain_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v0, r0, sc0, sl0, b0, dn0;
    logic [7:0]  d0;
    logic [0:0]  sd0;
    logic        v1, r1, sc1, sl1, b1, dn1;
    logic [7:0]  d1;
    logic [0:0]  sd1;
    logic        v2, r2, sc2, sl2, b2, dn2;
    logic [15:0] d2;
    logic [1:0]  sd2;

    led_shift_chain_driver #(.WIDTH(8), .NUM_CHAINS(1), .CLK_DIV(0), .LATCH_TICKS(1), .LSB_FIRST(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_valid(v0), .frame_ready(r0), .frame_data(d0),
        .sdata(sd0), .sclk(sc0), .slatch(sl0), .busy(b0), .done(dn0));

    led_shift_chain_driver #(.WIDTH(8), .NUM_CHAINS(1), .CLK_DIV(3), .LATCH_TICKS(1), .LSB_FIRST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_valid(v1), .frame_ready(r1), .frame_data(d1),
        .sdata(sd1), .sclk(sc1), .slatch(sl1), .busy(b1), .done(dn1));

    led_shift_chain_driver #(.WIDTH(8), .NUM_CHAINS(2), .CLK_DIV(0), .LATCH_TICKS(2), .LSB_FIRST(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .frame_valid(v2), .frame_ready(r2), .frame_data(d2),
        .sdata(sd2), .sclk(sc2), .slatch(sl2), .busy(b2), .done(dn2));

    int total;
    int bad;
    int t;
    logic p0, p1, p2;
    logic rise0, rise1, rise2;

    logic       exp0[$];
    logic       exp1[$];
    int         et1[$];
    logic [1:0] exp2[$];

    // Advance to the next falling edge and note fresh sclk rises.
    task automatic cycle();
        @(negedge clk);
        t++;
        rise0 = sc0 && !p0; p0 = sc0;
        rise1 = sc1 && !p1; p1 = sc1;
        rise2 = sc2 && !p2; p2 = sc2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
        exp0.delete(); exp1.delete(); et1.delete(); exp2.delete();
    endtask

    task automatic push0(input logic [7:0] d);
        for (int k = 0; k < 8; k++) exp0.push_back(d[7-k]);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({r0, sd0, sc0, sl0, b0, dn0} !== 6'b100000) begin
            bad++; $display("FAIL reset_dut0: got %b want 100000", {r0, sd0, sc0, sl0, b0, dn0});
        end
        total++;
        if ({r1, sd1, sc1, sl1, b1, dn1} !== 6'b100000) begin
            bad++; $display("FAIL reset_dut1: got %b want 100000", {r1, sd1, sc1, sl1, b1, dn1});
        end
        total++;
        if ({r2, sd2, sc2, sl2, b2, dn2} !== 7'b1000000) begin
            bad++; $display("FAIL reset_dut2: got %b want 1000000", {r2, sd2, sc2, sl2, b2, dn2});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int ns = 0;
        int td = -1;
        logic e;
        do_reset();
        push0(8'hA5);
        v0 = 1'b1; d0 = 8'hA5; t = -1;
        cycle();
        v0 = 1'b0;
        total++;
        if ({b0, r0, sd0} !== 3'b101) begin
            bad++; $display("FAIL basic_accept: busy/ready/sdata got %b want 101", {b0, r0, sd0});
        end
        while (td < 0 && t < 100) begin
            cycle();
            if (rise0) begin
                total++;
                if (exp0.size() == 0) begin
                    bad++; $display("FAIL basic_extra_rise: got rise at t=%0d want none", t);
                end else begin
                    e = exp0.pop_front();
                    if (sd0 !== e) begin bad++; $display("FAIL basic_bit: got %b want %b at t=%0d", sd0, e, t); end
                end
            end
            if (sl0) begin
                ns++;
                total++;
                if ({sc0, sd0} !== 2'b00) begin bad++; $display("FAIL basic_latch_lines: got %b want 00", {sc0, sd0}); end
            end
            if (dn0) td = t;
        end
        total++;
        if (td !== 17) begin bad++; $display("FAIL basic_done_time: got %0d want 17", td); end
        total++;
        if (ns !== 1) begin bad++; $display("FAIL basic_latch_len: got %0d want 1", ns); end
        total++;
        if ({r0, b0, sl0} !== 3'b100) begin bad++; $display("FAIL basic_done_state: got %b want 100", {r0, b0, sl0}); end
        total++;
        if (exp0.size() != 0) begin bad++; $display("FAIL basic_missing_rises: got %0d left want 0", exp0.size()); end
    endtask

    task automatic test_lsb_div();
        int td = -1;
        int et;
        logic e;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exp1.push_back(k == 0);
            et1.push_back((2 * k + 1) * 4);
        end
        v1 = 1'b1; d1 = 8'h01; t = -1;
        cycle();
        v1 = 1'b0;
        total++;
        if (sd1 !== 1'b1) begin bad++; $display("FAIL lsb_first_bit: got %b want 1", sd1); end
        while (td < 0 && t < 300) begin
            cycle();
            if (rise1) begin
                total++;
                if (exp1.size() == 0) begin
                    bad++; $display("FAIL lsb_extra_rise: got rise at t=%0d want none", t);
                end else begin
                    e = exp1.pop_front();
                    et = et1.pop_front();
                    if (sd1 !== e || t != et) begin
                        bad++; $display("FAIL lsb_bit: got %b@%0d want %b@%0d", sd1, t, e, et);
                    end
                end
            end
            if (dn1) td = t;
        end
        total++;
        if (td !== 68) begin bad++; $display("FAIL lsb_done_time: got %0d want 68", td); end
        total++;
        if (exp1.size() != 0) begin bad++; $display("FAIL lsb_missing_rises: got %0d left want 0", exp1.size()); end
    endtask

    task automatic test_chains();
        int ns = 0;
        int td = -1;
        logic [15:0] d;
        logic [1:0] e;
        do_reset();
        d = 16'hF00F;
        for (int k = 0; k < 8; k++) exp2.push_back({d[15-k], d[7-k]});
        v2 = 1'b1; d2 = d; t = -1;
        cycle();
        v2 = 1'b0;
        d2 = 16'h0000;
        while (td < 0 && t < 100) begin
            cycle();
            if (rise2) begin
                total++;
                if (exp2.size() == 0) begin
                    bad++; $display("FAIL chains_extra_rise: got rise at t=%0d want none", t);
                end else begin
                    e = exp2.pop_front();
                    if (sd2 !== e) begin bad++; $display("FAIL chains_bits: got %b want %b at t=%0d", sd2, e, t); end
                end
            end
            if (sl2) ns++;
            if (dn2) td = t;
        end
        total++;
        if (td !== 18) begin bad++; $display("FAIL chains_done_time: got %0d want 18", td); end
        total++;
        if (ns !== 2) begin bad++; $display("FAIL chains_latch_len: got %0d want 2", ns); end
        total++;
        if (exp2.size() != 0) begin bad++; $display("FAIL chains_missing_rises: got %0d left want 0", exp2.size()); end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        int td1 = -1;
        int td2 = -1;
        int nidle = 0;
        logic e;
        do_reset();
        push0(8'h55);
        push0(8'hAA);
        v0 = 1'b1; d0 = 8'h55; t = -1;
        cycle();
        d0 = 8'hAA;
        while (nd < 2 && t < 120) begin
            cycle();
            if (rise0) begin
                total++;
                if (exp0.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_rise: got rise at t=%0d want none", t);
                end else begin
                    e = exp0.pop_front();
                    if (sd0 !== e) begin bad++; $display("FAIL b2b_bit: got %b want %b at t=%0d", sd0, e, t); end
                end
            end
            if (r0 && !dn0) nidle++;
            if (r0 && nd == 0) nidle++;
            if (dn0) begin
                nd++;
                if (nd == 1) td1 = t; else td2 = t;
            end
            if (t == 18) begin
                v0 = 1'b0;
                total++;
                if ({b0, r0} !== 2'b10) begin bad++; $display("FAIL b2b_second_accept: got %b want 10", {b0, r0}); end
            end
        end
        total++;
        if (td1 !== 17 || td2 !== 35) begin
            bad++; $display("FAIL b2b_done_times: got %0d,%0d want 17,35", td1, td2);
        end
        total++;
        if (nidle !== 1) begin bad++; $display("FAIL b2b_idle_cycles: got %0d want 1", nidle); end
        total++;
        if (exp0.size() != 0) begin bad++; $display("FAIL b2b_missing_rises: got %0d left want 0", exp0.size()); end
    endtask

    task automatic test_midframe_reset();
        int nr = 0;
        int td = -1;
        logic e;
        do_reset();
        v0 = 1'b1; d0 = 8'h96; t = -1;
        cycle();
        v0 = 1'b0;
        while (nr < 3 && t < 50) begin
            cycle();
            if (rise0) nr++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({r0, sd0, sc0, sl0, b0, dn0} !== 6'b100000) begin
            bad++; $display("FAIL midreset_outputs: got %b want 100000", {r0, sd0, sc0, sl0, b0, dn0});
        end
        p0 = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if ({sl0, b0, r0} !== 3'b001) begin
                bad++; $display("FAIL midreset_quiet: got %b want 001", {sl0, b0, r0});
            end
        end
        push0(8'hFF);
        v0 = 1'b1; d0 = 8'hFF; t = -1;
        cycle();
        v0 = 1'b0;
        while (td < 0 && t < 100) begin
            cycle();
            if (rise0) begin
                total++;
                if (exp0.size() == 0) begin
                    bad++; $display("FAIL midreset_extra_rise: got rise at t=%0d want none", t);
                end else begin
                    e = exp0.pop_front();
                    if (sd0 !== e) begin bad++; $display("FAIL midreset_bit: got %b want %b", sd0, e); end
                end
            end
            if (dn0) td = t;
        end
        total++;
        if (td !== 17 || exp0.size() != 0) begin
            bad++; $display("FAIL midreset_next_frame: got done=%0d left=%0d want 17,0", td, exp0.size());
        end
    endtask

`ifdef LED_SHIFT_REPEAT_EN
    task automatic test_repeat();
        int dts[$];
        logic e;
        do_reset();
        push0(8'h3C); push0(8'h3C); push0(8'h3C);
        push0(8'hC3); push0(8'hC3);
        v0 = 1'b1; d0 = 8'h3C; t = -1;
        cycle();
        v0 = 1'b0;
        while (dts.size() < 5 && t < 200) begin
            cycle();
            if (rise0) begin
                total++;
                if (exp0.size() == 0) begin
                    bad++; $display("FAIL repeat_extra_rise: got rise at t=%0d want none", t);
                end else begin
                    e = exp0.pop_front();
                    if (sd0 !== e) begin bad++; $display("FAIL repeat_bit: got %b want %b at t=%0d", sd0, e, t); end
                end
            end
            if (dn0) dts.push_back(t);
            if (t == 40) begin v0 = 1'b1; d0 = 8'hC3; end
            if (t == 54) v0 = 1'b0;
        end
        total++;
        if (dts.size() != 5) begin
            bad++; $display("FAIL repeat_done_count: got %0d want 5", dts.size());
        end
        for (int i = 0; i < dts.size(); i++) begin
            total++;
            if (dts[i] != 17 + 18 * i) begin
                bad++; $display("FAIL repeat_done_time: got %0d want %0d", dts[i], 17 + 18 * i);
            end
        end
    endtask
`else
    task automatic test_repeat();
        int td = -1;
        int nb = 0;
        do_reset();
        v0 = 1'b1; d0 = 8'h3C; t = -1;
        cycle();
        v0 = 1'b0;
        while (td < 0 && t < 100) begin
            cycle();
            if (dn0) td = t;
        end
        total++;
        if (td !== 17) begin bad++; $display("FAIL norepeat_done_time: got %0d want 17", td); end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (b0 || sc0 || dn0) nb++;
        end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL norepeat_idle: got %0d active cycles want 0", nb); end
    endtask
`endif

    initial begin
        total = 0; bad = 0; t = 0;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
        rise0 = 1'b0; rise1 = 1'b0; rise2 = 1'b0;
        test_reset();
        test_basic();
        test_lsb_div();
        test_chains();
        test_back_to_back();
        test_midframe_reset();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
